sc_psr_flags: RTL and testbench
===============================

Name: sc_psr_flags

Overview:
- Processor status register (PSR) stage directly downstream of the ALU.
- Captures the ALU's four active-low condition flags (N, Z, V, C) into the integer condition code (icc) field of a 32-bit PSR.
- Supports explicit PSR write/read over the data bus.
- Evaluates SPARC-style branch conditions against the committed flags for the control unit; registered, one-cycle result.

Parameters:
- DATAWIDTH_BUS, 32, width of PSR and data buses.
- DATAWIDTH_COND, 4, width of branch condition field.
- PSR_RESET_VALUE, 32'h0000_0000, PSR contents after reset.
- PSR_WRITE_MASK, 32'hFFFF_FFFF, bits writable through SC_PSR_write_In; non-writable bits hold their value.

Ports:
- SC_PSR_CLOCK_50  in  1  system clock, rising edge.
- SC_PSR_RESET_InHigh  in  1  synchronous reset, active-high.
- SC_PSR_negative_InLow  in  1  ALU N flag, active-low.
- SC_PSR_zero_InLow  in  1  ALU Z flag, active-low.
- SC_PSR_overflow_InLow  in  1  ALU V flag, active-low.
- SC_PSR_carry_InLow  in  1  ALU C flag, active-low.
- SC_PSR_setFlags_In  in  1  load icc from ALU flags this cycle.
- SC_PSR_write_In  in  1  load PSR from data bus (wrpsr).
- SC_PSR_data_InBUS  in  DATAWIDTH_BUS  write data.
- SC_PSR_stall_In  in  1  freeze all state.
- SC_PSR_cond_InBUS  in  DATAWIDTH_COND  branch condition code.
- SC_PSR_condValid_In  in  1  request condition evaluation.
- SC_PSR_data_OutBUS  out  DATAWIDTH_BUS  current PSR (registered).
- SC_PSR_flags_OutBUS  out  4  {N,Z,V,C}, active-high, = PSR[23:20].
- SC_PSR_branchTaken_Out  out  1  registered evaluation result.
- SC_PSR_branchValid_Out  out  1  registered, qualifies branchTaken.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. While SC_PSR_RESET_InHigh=1 at a rising edge: PSR<=PSR_RESET_VALUE, branchTaken<=0, branchValid<=0. Reset overrides stall and every other input.
- icc layout: PSR[23]=N, PSR[22]=Z, PSR[21]=V, PSR[20]=C, all stored active-high (inverted from the inputs).
- Update priority per edge, when not stalled:
  - write=1: PSR <= (data_In & MASK) | (PSR & ~MASK); setFlags is ignored.
  - else setFlags=1: PSR[23:20] <= ~{negative,zero,overflow,carry}_InLow; other bits are unchanged.
  - else: PSR holds.
- Stall=1: PSR, branchTaken and branchValid all hold their values. A condValid presented during a stall is dropped.
- Condition evaluation (combinational sub-module, result registered):
  - Uses the PSR value *before* the current edge. There is no forwarding from the same-cycle setFlags; the control unit inserts one cycle between a flag-setting op and a dependent branch.
  - Conditions: 1000 ba=1; 0000 bn=0; 0001 be=Z; 1001 bne=~Z; 0101 bcs=C; 1101 bcc=~C; 0110 bneg=N; 1110 bpos=~N; 0111 bvs=V; 1111 bvc=~V.
  - Signed/unsigned: 0010 ble=Z|(N^V); 1010 bg=~(Z|(N^V)); 0011 bl=N^V; 1011 bge=~(N^V); 0100 bleu=C|Z; 1100 bgu=~(C|Z).
- Branch outputs:
  - Not stalled: branchValid <= condValid.
  - branchTaken <= condValid & eval; branchTaken is 0 whenever branchValid is 0.
  - Latency is one cycle from condValid to branchValid.
- Outputs: data_OutBUS and flags_OutBUS are direct register outputs, with zero combinational path from inputs.
- Simultaneous write and condValid: evaluation uses the old flags; the new PSR is visible the next cycle.
- Reset mid-evaluation: the pending result is discarded and branchValid=0 on the next cycle.

Decomposition:
- Shared package holds:
  - condition code constants (COND_BA, COND_BN, COND_BE, ... COND_BVC);
  - icc bit positions (ICC_N=23, ICC_Z=22, ICC_V=21, ICC_C=20);
  - PSR_RESET_VALUE default.
- One combinational sub-module, sc_psr_cond_eval: inputs are cond[3:0] and nzvc[3:0]; output is taken.

Test Plan:
- Reset: RESET_InHigh=1 for 2 cycles with write=1, data=32'hFFFF_FFFF -> data_OutBUS=0, flags=0000, branchValid=0.
- Flag capture: setFlags=1 with InLow flags N=0,Z=1,V=1,C=0 -> next cycle flags_OutBUS=4'b1001, data_OutBUS=32'h0090_0000.
- Write priority: write=1, data=32'h00F0_0000 and setFlags=1 with all InLow=1 in the same cycle -> flags=4'b1111. Then setFlags=1 with all InLow=1 -> flags=4'b0000.
- Condition sweep: for each of the 16 nzvc values, drive all 16 cond codes with condValid=1 -> branchTaken matches the table one cycle later; cond=0000 always gives 0, cond=1000 always gives 1.
- No bypass: flags=0000; setFlags (Z InLow=0) and condValid cond=0001 (be) in the same cycle -> branchTaken=0. Repeat be the next cycle -> branchTaken=1.
- Stall: with stall=1, apply setFlags, write and condValid -> PSR and branch outputs unchanged. Deassert stall -> normal update resumes on the next edge.

Source files
------------

// File: rtl/sc_psr_flags_pkg.sv
// Shared definitions for the PSR flag stage: branch condition encodings,
// icc bit positions inside the PSR and the default reset image.
package sc_psr_flags_pkg;

    localparam int ICC_N = 23;
    localparam int ICC_Z = 22;
    localparam int ICC_V = 21;
    localparam int ICC_C = 20;

    localparam logic [31:0] PSR_RESET_DEFAULT = 32'h0000_0000;

    // Bit 3 of every code inverts the sense of the condition in bits [2:0].
    typedef enum logic [3:0] {
        COND_BN   = 4'b0000,
        COND_BE   = 4'b0001,
        COND_BLE  = 4'b0010,
        COND_BL   = 4'b0011,
        COND_BLEU = 4'b0100,
        COND_BCS  = 4'b0101,
        COND_BNEG = 4'b0110,
        COND_BVS  = 4'b0111,
        COND_BA   = 4'b1000,
        COND_BNE  = 4'b1001,
        COND_BG   = 4'b1010,
        COND_BGE  = 4'b1011,
        COND_BGU  = 4'b1100,
        COND_BCC  = 4'b1101,
        COND_BPOS = 4'b1110,
        COND_BVC  = 4'b1111
    } cond_e;

    typedef struct packed {
        logic n;
        logic z;
        logic v;
        logic c;
    } icc_t;

endpackage

// File: rtl/sc_psr_cond_eval.sv
// Combinational SPARC branch-condition evaluator over the committed icc flags.
module sc_psr_cond_eval
    import sc_psr_flags_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] nzvc,
    output logic       taken
);

    icc_t icc;
    logic base;

    assign icc = nzvc;

    always_comb begin
        base = 1'b0;
        case ({1'b0, cond[2:0]})
            COND_BN:   base = 1'b0;
            COND_BE:   base = icc.z;
            COND_BLE:  base = icc.z | (icc.n ^ icc.v);
            COND_BL:   base = icc.n ^ icc.v;
            COND_BLEU: base = icc.c | icc.z;
            COND_BCS:  base = icc.c;
            COND_BNEG: base = icc.n;
            COND_BVS:  base = icc.v;
            default:   base = 1'b0;
        endcase
    end

    assign taken = base ^ cond[3];

endmodule

// File: rtl/sc_psr_flags.sv
// PSR stage behind the ALU: captures active-low ALU flags into icc, supports
// wrpsr, and registers a one-cycle branch evaluation against the old flags.
module sc_psr_flags
    import sc_psr_flags_pkg::*;
#(
    parameter int                         DATAWIDTH_BUS   = 32,
    parameter int                         DATAWIDTH_COND  = 4,
    parameter logic [DATAWIDTH_BUS-1:0]   PSR_RESET_VALUE = PSR_RESET_DEFAULT,
    parameter logic [DATAWIDTH_BUS-1:0]   PSR_WRITE_MASK  = 32'hFFFF_FFFF
) (
    input  logic                      SC_PSR_CLOCK_50,
    input  logic                      SC_PSR_RESET_InHigh,
    input  logic                      SC_PSR_negative_InLow,
    input  logic                      SC_PSR_zero_InLow,
    input  logic                      SC_PSR_overflow_InLow,
    input  logic                      SC_PSR_carry_InLow,
    input  logic                      SC_PSR_setFlags_In,
    input  logic                      SC_PSR_write_In,
    input  logic [DATAWIDTH_BUS-1:0]  SC_PSR_data_InBUS,
    input  logic                      SC_PSR_stall_In,
    input  logic [DATAWIDTH_COND-1:0] SC_PSR_cond_InBUS,
    input  logic                      SC_PSR_condValid_In,
    output logic [DATAWIDTH_BUS-1:0]  SC_PSR_data_OutBUS,
    output logic [3:0]                SC_PSR_flags_OutBUS,
    output logic                      SC_PSR_branchTaken_Out,
    output logic                      SC_PSR_branchValid_Out
);

    logic [DATAWIDTH_BUS-1:0] psr_reg;
    logic [DATAWIDTH_BUS-1:0] psr_next;
    logic                     branch_taken_reg;
    logic                     branch_valid_reg;
    logic [3:0]               icc_in;
    logic                     eval_taken;

    assign icc_in = ~{SC_PSR_negative_InLow, SC_PSR_zero_InLow,
                      SC_PSR_overflow_InLow, SC_PSR_carry_InLow};

    // Per-bit next value: wrpsr beats setFlags; masked-off bits never take bus data.
    genvar gi;
    generate
        for (gi = 0; gi < DATAWIDTH_BUS; gi++) begin : g_psr_bit
            logic wr_bit;
            if (PSR_WRITE_MASK[gi]) begin : g_wr
                assign wr_bit = SC_PSR_data_InBUS[gi];
            end else begin : g_keep
                assign wr_bit = psr_reg[gi];
            end

            if (gi >= ICC_C && gi <= ICC_N) begin : g_icc
                assign psr_next[gi] = SC_PSR_write_In    ? wr_bit :
                                      SC_PSR_setFlags_In ? icc_in[gi-ICC_C] :
                                                           psr_reg[gi];
            end else begin : g_plain
                assign psr_next[gi] = SC_PSR_write_In ? wr_bit : psr_reg[gi];
            end
        end
    endgenerate

    // Evaluation sees the flags already committed, never this cycle's update.
    sc_psr_cond_eval u_cond_eval (
        .cond  (SC_PSR_cond_InBUS[3:0]),
        .nzvc  (psr_reg[ICC_N:ICC_C]),
        .taken (eval_taken)
    );

    always_ff @(posedge SC_PSR_CLOCK_50) begin
        if (SC_PSR_RESET_InHigh) begin
            psr_reg          <= PSR_RESET_VALUE;
            branch_taken_reg <= 1'b0;
            branch_valid_reg <= 1'b0;
        end else if (!SC_PSR_stall_In) begin
            psr_reg          <= psr_next;
            branch_valid_reg <= SC_PSR_condValid_In;
            branch_taken_reg <= SC_PSR_condValid_In & eval_taken;
        end
    end

    assign SC_PSR_data_OutBUS     = psr_reg;
    assign SC_PSR_flags_OutBUS    = psr_reg[ICC_N:ICC_C];
    assign SC_PSR_branchTaken_Out = branch_taken_reg;
    assign SC_PSR_branchValid_Out = branch_valid_reg;

endmodule

// File: tb/tb_sc_psr_flags.sv
// Scoreboard bench for sc_psr_flags: driver predicts with a reference model,
// a negedge monitor pops and compares every registered output.
module tb_sc_psr_flags;

    localparam logic [31:0] RST_VAL = 32'h0000_0000;
    localparam logic [31:0] MASK    = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst;
    logic        n_low, z_low, v_low, c_low;
    logic        set_flags;
    logic        wr;
    logic [31:0] data_in;
    logic        stall;
    logic [3:0]  cond;
    logic        cond_valid;
    logic [31:0] data_out;
    logic [3:0]  flags_out;
    logic        branch_taken;
    logic        branch_valid;

    always #5 clk = ~clk;

    sc_psr_flags dut (
        .SC_PSR_CLOCK_50        (clk),
        .SC_PSR_RESET_InHigh    (rst),
        .SC_PSR_negative_InLow  (n_low),
        .SC_PSR_zero_InLow      (z_low),
        .SC_PSR_overflow_InLow  (v_low),
        .SC_PSR_carry_InLow     (c_low),
        .SC_PSR_setFlags_In     (set_flags),
        .SC_PSR_write_In        (wr),
        .SC_PSR_data_InBUS      (data_in),
        .SC_PSR_stall_In        (stall),
        .SC_PSR_cond_InBUS      (cond),
        .SC_PSR_condValid_In    (cond_valid),
        .SC_PSR_data_OutBUS     (data_out),
        .SC_PSR_flags_OutBUS    (flags_out),
        .SC_PSR_branchTaken_Out (branch_taken),
        .SC_PSR_branchValid_Out (branch_valid)
    );

    typedef struct {
        int unsigned due;
        logic [31:0] psr;
        logic        bv;
        logic        bt;
        string       tag;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int unsigned cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;

    logic [31:0] m_psr;
    logic        m_bv;
    logic        m_bt;

    always @(posedge clk) cyc <= cyc + 1;

    // Branch truth table written out code by code from the condition list.
    function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
        logic n, z, v, cy;
        n = f[3]; z = f[2]; v = f[1]; cy = f[0];
        case (c)
            4'b1000: return 1'b1;
            4'b0000: return 1'b0;
            4'b0001: return z;
            4'b1001: return !z;
            4'b0101: return cy;
            4'b1101: return !cy;
            4'b0110: return n;
            4'b1110: return !n;
            4'b0111: return v;
            4'b1111: return !v;
            4'b0010: return z || (n != v);
            4'b1010: return !(z || (n != v));
            4'b0011: return n != v;
            4'b1011: return n == v;
            4'b0100: return cy || z;
            4'b1100: return !(cy || z);
            default: return 1'b0;
        endcase
    endfunction

    // nzvc_low is {N,Z,V,C} as driven on the active-low pins.
    task automatic step(input string tag, input logic rst_i, input logic stall_i,
                        input logic wr_i, input logic [31:0] d_i, input logic sf_i,
                        input logic [3:0] nzvc_low, input logic cv_i, input logic [3:0] cond_i);
        exp_t e;
        logic t;
        @(posedge clk);
        #1;
        rst = rst_i; stall = stall_i; wr = wr_i; data_in = d_i; set_flags = sf_i;
        {n_low, z_low, v_low, c_low} = nzvc_low;
        cond_valid = cv_i; cond = cond_i;
        if (rst_i) begin
            m_psr = RST_VAL; m_bv = 1'b0; m_bt = 1'b0;
        end else if (!stall_i) begin
            t = cv_i && ref_cond(cond_i, m_psr[23:20]);
            if (wr_i)
                m_psr = (d_i & MASK) | (m_psr & ~MASK);
            else if (sf_i)
                m_psr[23:20] = ~nzvc_low;
            m_bv = cv_i;
            m_bt = t;
        end
        e.due = cyc + 1; e.psr = m_psr; e.bv = m_bv; e.bt = m_bt; e.tag = tag;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            mon_e = sb.pop_front();
            vectors++;
            if (data_out !== mon_e.psr || flags_out !== mon_e.psr[23:20] ||
                branch_valid !== mon_e.bv || branch_taken !== mon_e.bt) begin
                miscompares++;
                $display("FAIL %s: got psr=%h flags=%b bv=%b bt=%b, expected psr=%h flags=%b bv=%b bt=%b",
                         mon_e.tag, data_out, flags_out, branch_valid, branch_taken,
                         mon_e.psr, mon_e.psr[23:20], mon_e.bv, mon_e.bt);
            end else begin
                $display("chk %s: psr=%h flags=%b bv=%b bt=%b ok",
                         mon_e.tag, data_out, flags_out, branch_valid, branch_taken);
            end
        end
    end

    initial begin
        logic        r_rst, r_stall, r_wr, r_sf, r_cv;
        logic [31:0] r_data;
        logic [3:0]  r_flags, r_cond;

        rst = 1'b1; stall = 1'b0; wr = 1'b0; data_in = '0; set_flags = 1'b0;
        {n_low, z_low, v_low, c_low} = 4'hF; cond_valid = 1'b0; cond = '0;
        m_psr = RST_VAL; m_bv = 1'b0; m_bt = 1'b0;

        step("reset0", 1, 0, 1, 32'hFFFF_FFFF, 1, 4'h0, 1, 4'b1000);
        step("reset1", 1, 0, 1, 32'hFFFF_FFFF, 1, 4'h0, 1, 4'b1000);

        step("flag_capture", 0, 0, 0, 32'h0, 1, 4'b0110, 0, 4'h0);
        step("write_prio",   0, 0, 1, 32'h00F0_0000, 1, 4'hF, 0, 4'h0);
        step("flags_clear",  0, 0, 0, 32'h0, 1, 4'hF, 0, 4'h0);

        for (int f = 0; f < 16; f++) begin
            r_data = 32'(f) << 20;
            step("sweep_load", 0, 0, 1, r_data, 0, 4'hF, 0, 4'h0);
            for (int c = 0; c < 16; c++)
                step("sweep_cond", 0, 0, 0, 32'h0, 0, 4'hF, 1, 4'(c));
        end

        step("nobyp_clear", 0, 0, 1, 32'h0, 0, 4'hF, 0, 4'h0);
        step("nobyp_same",  0, 0, 0, 32'h0, 1, 4'b1011, 1, 4'b0001);
        step("nobyp_next",  0, 0, 0, 32'h0, 0, 4'hF, 1, 4'b0001);

        step("stall_setup", 0, 0, 1, 32'h00A0_1234, 0, 4'hF, 1, 4'b1000);
        step("stall_sf",    0, 1, 0, 32'h0, 1, 4'h0, 1, 4'b0000);
        step("stall_wr",    0, 1, 1, 32'hDEAD_BEEF, 0, 4'hF, 1, 4'b0000);
        step("stall_cv",    0, 1, 0, 32'h0, 0, 4'hF, 1, 4'b0000);
        step("stall_resume",0, 0, 1, 32'h0050_0001, 0, 4'hF, 1, 4'b0000);

        step("rst_mid_req", 0, 0, 0, 32'h0, 0, 4'hF, 1, 4'b1000);
        step("rst_mid",     1, 1, 0, 32'h0, 0, 4'hF, 1, 4'b1000);

        for (int i = 0; i < 1500; i++) begin
            r_rst   = ($urandom_range(0, 63) == 0);
            r_stall = ($urandom_range(0, 4) == 0);
            r_wr    = ($urandom_range(0, 5) == 0);
            r_sf    = $urandom_range(0, 1) == 1;
            r_cv    = $urandom_range(0, 1) == 1;
            r_data  = $urandom();
            r_flags = 4'($urandom_range(0, 15));
            r_cond  = 4'($urandom_range(0, 15));
            step("random", r_rst, r_stall, r_wr, r_data, r_sf, r_flags, r_cv, r_cond);
        end

        step("idle", 0, 0, 0, 32'h0, 0, 4'hF, 0, 4'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d entries left, expected 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
